// File: rtl/cabac_ctx_pkg.sv
// Shared constants, RAM word/byte layout and FSM encoding for the CABAC context manager.
package cabac_ctx_pkg;

  localparam int CTX_NUM = 128;
  localparam int AW      = 6;
  localparam int QP_MAX  = 51;

  localparam int IDX_W   = 7;
  localparam int STATE_W = 7;
  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 16;

  // byte = {1'b0, pStateIdx[5:0], valMps}; even contexts live in the low byte
  localparam int LO_LSB     = 0;
  localparam int HI_LSB     = 8;
  localparam int VALMPS_BIT = 0;
  localparam int PSTATE_LSB = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } ctx_fsm_e;

  function automatic logic [5:0] qp_clip(input logic [5:0] qp);
    return (qp > 6'(QP_MAX)) ? 6'(QP_MAX) : qp;
  endfunction

endpackage

// File: rtl/cabac_ctx_init_calc.sv
// Combinational initValue + clipped QP -> 7-bit context state {pStateIdx, valMps}.
module cabac_ctx_init_calc
  import cabac_ctx_pkg::*;
(
  input  logic [7:0]         init_val_i,
  input  logic [5:0]         qp_i,
  output logic [STATE_W-1:0] state_o
);

  logic signed [7:0]  w_m;
  logic signed [7:0]  w_n;
  logic signed [13:0] w_m_ext;
  logic signed [13:0] w_n_ext;
  logic signed [13:0] w_qp_ext;
  logic signed [13:0] w_prod;
  logic signed [13:0] w_sum;
  logic [6:0]         w_pre;

  assign w_m      = $signed({4'b0000, init_val_i[7:4]}) * 8'sd5 - 8'sd45;
  assign w_n      = $signed({1'b0, init_val_i[3:0], 3'b000}) - 8'sd16;
  assign w_m_ext  = {{6{w_m[7]}}, w_m};
  assign w_n_ext  = {{6{w_n[7]}}, w_n};
  assign w_qp_ext = $signed({8'b0, qp_i});
  assign w_prod   = w_m_ext * w_qp_ext;
  assign w_sum    = (w_prod >>> 4) + w_n_ext;

  always_comb begin
    w_pre = w_sum[6:0];
    if (w_sum < 14'sd1)
      w_pre = 7'd1;
    else if (w_sum > 14'sd126)
      w_pre = 7'd126;
  end

  // pre lies in 1..126, so pre[6] is valMps and 63-pre is the bitwise inverse of pre[5:0]
  assign state_o[VALMPS_BIT]       = w_pre[6];
  assign state_o[PSTATE_LSB +: 6]  = w_pre[6] ? w_pre[5:0] : ~w_pre[5:0];

endmodule

// File: rtl/cabac_ctx_mgr.sv
// CABAC context-model manager: slice-start init from ROM and a coherent read/update path.
// Optional accepted read/write counters are built when CABAC_CTX_STAT_EN is defined.
module cabac_ctx_mgr
  import cabac_ctx_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               slice_start_i,
  input  logic [5:0]         slice_qp_i,
  input  logic [1:0]         init_type_i,
  output logic               init_busy_o,
  output logic               init_done_o,
  output logic [8:0]         rom_idx_o,
  input  logic [7:0]         rom_val_i,
  input  logic               ctx_rd_i,
  input  logic [IDX_W-1:0]   ctx_idx_i,
  output logic               ctx_rdy_o,
  output logic               ctx_vld_o,
  output logic [STATE_W-1:0] ctx_state_o,
  input  logic               ctx_wr_i,
  input  logic [IDX_W-1:0]   ctx_wr_idx_i,
  input  logic [STATE_W-1:0] ctx_wr_state_i,
  output logic               ram_cen_o,
  output logic               ram_wen_o,
  output logic [AW-1:0]      ram_addr_o,
  output logic [WORD_W-1:0]  ram_data_o,
  input  logic [WORD_W-1:0]  ram_data_i
`ifdef CABAC_CTX_STAT_EN
  ,
  output logic [15:0]        ctx_rd_cnt_o,
  output logic [15:0]        ctx_wr_cnt_o
`endif
);

  ctx_fsm_e            r_state, w_state_next;
  logic [IDX_W-1:0]    r_cnt, w_cnt_next;
  logic [5:0]          r_qpc;
  logic [1:0]          r_type;
  logic [BYTE_W-1:0]   r_lo_byte;
  logic                r_done;

  logic                r_buf_vld;
  logic [AW-1:0]       r_buf_addr;
  logic [WORD_W-1:0]   r_buf_data;

  logic                r_vld;
  logic                r_rd_sel;
  logic                r_byp;
  logic [WORD_W-1:0]   r_byp_word;
  logic [WORD_W-1:0]   r_last_word;

  logic [STATE_W-1:0]  w_init_state;
  logic                w_idle;
  logic                w_rd_acc;
  logic                w_wr_en;
  logic                w_wr_hit_buf;
  logic                w_commit;
  logic [WORD_W-1:0]   w_rd_word;
  logic [WORD_W-1:0]   w_base;
  logic [WORD_W-1:0]   w_merged;

  cabac_ctx_init_calc u_calc (
    .init_val_i (rom_val_i),
    .qp_i       (r_qpc),
    .state_o    (w_init_state)
  );

  assign w_idle      = (r_state == ST_IDLE);
  assign init_busy_o = (r_state == ST_INIT);
  assign init_done_o = r_done;
  assign rom_idx_o   = {r_type, r_cnt};
  assign ctx_rdy_o   = !init_busy_o && !(r_buf_vld && ctx_wr_i);
  assign ctx_vld_o   = r_vld;

  assign w_rd_acc     = ctx_rd_i && ctx_rdy_o;
  // a slice start in IDLE throws away the buffer, so a write arriving with it is dropped too
  assign w_wr_en      = ctx_wr_i && w_idle && !slice_start_i;
  assign w_wr_hit_buf = w_wr_en && r_buf_vld && (ctx_wr_idx_i[IDX_W-1:1] == r_buf_addr);
  assign w_commit     = r_buf_vld && w_idle && !slice_start_i && !w_rd_acc && !w_wr_hit_buf;

  assign w_rd_word   = r_byp ? r_byp_word : ram_data_i;
  assign w_base      = r_vld ? w_rd_word : r_last_word;
  assign ctx_state_o = !r_vld   ? '0 :
                       r_rd_sel ? w_rd_word[HI_LSB +: STATE_W] : w_rd_word[LO_LSB +: STATE_W];

  always_comb begin
    w_merged = w_base;
    if (ctx_wr_idx_i[0])
      w_merged[HI_LSB +: BYTE_W] = {1'b0, ctx_wr_state_i};
    else
      w_merged[LO_LSB +: BYTE_W] = {1'b0, ctx_wr_state_i};
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (slice_start_i) begin
          w_state_next = ST_INIT;
          w_cnt_next   = '0;
        end
      end
      ST_INIT: begin
        if (slice_start_i) begin
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + 7'd1;
          if (r_cnt == 7'(CTX_NUM - 1))
            w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_qpc     <= '0;
      r_type    <= '0;
      r_lo_byte <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= init_busy_o && !slice_start_i && (r_cnt == 7'(CTX_NUM - 1));
      if (slice_start_i) begin
        r_qpc  <= qp_clip(slice_qp_i);
        r_type <= init_type_i;
      end
      if (init_busy_o && !r_cnt[0])
        r_lo_byte <= {1'b0, w_init_state};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else if (slice_start_i && w_idle) begin
      r_buf_vld <= 1'b0;
    end else if (w_wr_en) begin
      r_buf_vld  <= 1'b1;
      r_buf_addr <= ctx_wr_idx_i[IDX_W-1:1];
      r_buf_data <= w_merged;
    end else if (w_commit) begin
      r_buf_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_byp       <= 1'b0;
      r_byp_word  <= '0;
      r_last_word <= '0;
    end else begin
      r_vld <= w_rd_acc && !slice_start_i;
      if (r_vld)
        r_last_word <= w_rd_word;
      if (w_rd_acc) begin
        r_rd_sel <= ctx_idx_i[0];
        // the RAM word is stale if a same-cycle write or the pending buffer covers it
        if (w_wr_en && (ctx_wr_idx_i[IDX_W-1:1] == ctx_idx_i[IDX_W-1:1])) begin
          r_byp      <= 1'b1;
          r_byp_word <= w_merged;
        end else if (r_buf_vld && (r_buf_addr == ctx_idx_i[IDX_W-1:1])) begin
          r_byp      <= 1'b1;
          r_byp_word <= r_buf_data;
        end else begin
          r_byp <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (init_busy_o) begin
      if (r_cnt[0]) begin
        ram_cen_o  = 1'b0;
        ram_wen_o  = 1'b0;
        ram_addr_o = r_cnt[IDX_W-1:1];
        ram_data_o = {1'b0, w_init_state, r_lo_byte};
      end
    end else if (w_rd_acc) begin
      ram_cen_o  = 1'b0;
      ram_addr_o = ctx_idx_i[IDX_W-1:1];
    end else if (w_commit) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_addr_o = r_buf_addr;
      ram_data_o = r_buf_data;
    end
  end

`ifdef CABAC_CTX_STAT_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (slice_start_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_acc && (r_rd_cnt != 16'hFFFF))
        r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_wr_en && (r_wr_cnt != 16'hFFFF))
        r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign ctx_rd_cnt_o = r_rd_cnt;
  assign ctx_wr_cnt_o = r_wr_cnt;
`endif

endmodule

// File: tb/tb_cabac_ctx_mgr.sv
// Directed bench for cabac_ctx_mgr with a behavioural 64x16 RAM and a per-type/parity init ROM.
module tb_cabac_ctx_mgr;

  logic        clk;
  logic        rst_n;
  logic        slice_start_i;
  logic [5:0]  slice_qp_i;
  logic [1:0]  init_type_i;
  logic        init_busy_o;
  logic        init_done_o;
  logic [8:0]  rom_idx_o;
  logic [7:0]  rom_val_i;
  logic        ctx_rd_i;
  logic [6:0]  ctx_idx_i;
  logic        ctx_rdy_o;
  logic        ctx_vld_o;
  logic [6:0]  ctx_state_o;
  logic        ctx_wr_i;
  logic [6:0]  ctx_wr_idx_i;
  logic [6:0]  ctx_wr_state_i;
  logic        ram_cen_o;
  logic        ram_wen_o;
  logic [5:0]  ram_addr_o;
  logic [15:0] ram_data_o;
  logic [15:0] ram_data_i;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;

  logic [15:0] mem [0:63];
  logic [15:0] ram_q;
  logic [7:0]  rom_lut [0:3][0:1];

  cabac_ctx_mgr dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .slice_start_i  (slice_start_i),
    .slice_qp_i     (slice_qp_i),
    .init_type_i    (init_type_i),
    .init_busy_o    (init_busy_o),
    .init_done_o    (init_done_o),
    .rom_idx_o      (rom_idx_o),
    .rom_val_i      (rom_val_i),
    .ctx_rd_i       (ctx_rd_i),
    .ctx_idx_i      (ctx_idx_i),
    .ctx_rdy_o      (ctx_rdy_o),
    .ctx_vld_o      (ctx_vld_o),
    .ctx_state_o    (ctx_state_o),
    .ctx_wr_i       (ctx_wr_i),
    .ctx_wr_idx_i   (ctx_wr_idx_i),
    .ctx_wr_state_i (ctx_wr_state_i),
    .ram_cen_o      (ram_cen_o),
    .ram_wen_o      (ram_wen_o),
    .ram_addr_o     (ram_addr_o),
    .ram_data_o     (ram_data_o),
    .ram_data_i     (ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_cen_o) begin
      if (!ram_wen_o) mem[ram_addr_o] <= ram_data_o;
      else            ram_q <= mem[ram_addr_o];
    end
  end
  assign ram_data_i = ram_q;
  assign rom_val_i  = rom_lut[rom_idx_o[8:7]][rom_idx_o[0]];

  always @(negedge clk) begin
    if (init_done_o) done_cnt++;
    if (!ram_cen_o && !ram_wen_o) wr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_init(input logic [1:0] t, input logic [5:0] qp);
    slice_start_i = 1'b1;
    init_type_i   = t;
    slice_qp_i    = qp;
    tick();
    slice_start_i = 1'b0;
  endtask

  // n0 = cycles already elapsed since the start pulse was sampled
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!init_done_o && n < 400) begin
      tick();
      n++;
    end
  endtask

  function automatic int mem_bad(input logic [15:0] w);
    int bad = 0;
    for (int i = 0; i < 64; i++)
      if (mem[i] !== w) bad++;
    return bad;
  endfunction

  initial begin
    int n;
    int d0;
    int w0;

    for (int t = 0; t < 4; t++) begin
      rom_lut[t][0] = 8'h00;
      rom_lut[t][1] = 8'h00;
    end
    rom_lut[0][0] = 8'h9A; rom_lut[0][1] = 8'h9A;
    rom_lut[1][0] = 8'h8B; rom_lut[1][1] = 8'h9A;
    rom_lut[2][0] = 8'h8B; rom_lut[2][1] = 8'h8B;

    rst_n = 1'b1; slice_start_i = 1'b0; slice_qp_i = '0; init_type_i = '0;
    ctx_rd_i = 1'b0; ctx_idx_i = '0; ctx_wr_i = 1'b0; ctx_wr_idx_i = '0; ctx_wr_state_i = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_flags", {init_busy_o, init_done_o, ctx_vld_o, ram_cen_o, ram_wen_o}, 5'b00011);
    chk("rst_state", ctx_state_o, 7'h00);
    chk("rst_rom_idx", rom_idx_o, 9'h000);
    chk("rst_ram_bus", {ram_addr_o, ram_data_o}, 22'h0);
    rst_n = 1'b1;
    tick();

    // A: type 0, qp 26, ROM 0x9A -> every context {0,1}
    start_init(2'd0, 6'd26);
    chk("A_busy", init_busy_o, 1'b1);
    chk("A_rom_idx0", rom_idx_o, 9'h000);
    repeat (9) tick();
    ctx_rd_i = 1'b1; ctx_idx_i = 7'd3; ctx_wr_i = 1'b1; ctx_wr_idx_i = 7'd3; ctx_wr_state_i = 7'h7F;
    #1;
    chk("A_rdy_in_init", ctx_rdy_o, 1'b0);
    tick();
    ctx_rd_i = 1'b0; ctx_wr_i = 1'b0;
    chk("A_vld_in_init", ctx_vld_o, 1'b0);
    wait_done(11, n);
    chk("A_done_latency", n, 129);
    tick(); tick();
    chk("A_done_pulses", done_cnt, 1);
    chk("A_busy_after", init_busy_o, 1'b0);
    chk("A_words_bad", mem_bad(16'h0101), 0);
    ctx_rd_i = 1'b1; ctx_idx_i = 7'd6;
    tick();
    ctx_rd_i = 1'b0;
    chk("A_rd6_vld", ctx_vld_o, 1'b1);
    chk("A_rd6_state", ctx_state_o, 7'h01);
    tick();

    // B: type 1, even ROM 0x8B (pre 63 -> {0,0}), odd 0x9A -> word 0x0100
    start_init(2'd1, 6'd26);
    chk("B_rom_idx0", rom_idx_o, 9'h080);
    wait_done(1, n);
    chk("B_done_latency", n, 129);
    tick();
    chk("B_words_bad", mem_bad(16'h0100), 0);

    // C: type 2, ROM 0x8B, qp 63 clipped to 51 -> pre 56 -> {7,0} = 0x0E
    start_init(2'd2, 6'd63);
    chk("C_rom_idx0", rom_idx_o, 9'h100);
    wait_done(1, n);
    chk("C_done_latency", n, 129);
    tick();
    chk("C_words_bad", mem_bad(16'h0E0E), 0);
    ctx_rd_i = 1'b1; ctx_idx_i = 7'd3;
    tick();
    ctx_rd_i = 1'b0;
    chk("C_rd3_state", ctx_state_o, 7'h0E);
    tick();

    // D: restart at INIT cycle 60 with type 1
    d0 = done_cnt;
    start_init(2'd0, 6'd26);
    repeat (60) tick();
    chk("D_cnt60", rom_idx_o, 9'd60);
    start_init(2'd1, 6'd26);
    chk("D_restart_idx", rom_idx_o, 9'h080);
    wait_done(1, n);
    chk("D_done_latency", n, 129);
    tick(); tick();
    chk("D_done_pulses", done_cnt - d0, 1);
    chk("D_words_bad", mem_bad(16'h0100), 0);

    // E: read 5, update to {20,1}, re-read via buffer bypass, neighbour idx 4 intact
    ctx_rd_i = 1'b1; ctx_idx_i = 7'd5;
    #1;
    chk("E_rdy", ctx_rdy_o, 1'b1);
    tick();
    chk("E_rd5_vld", ctx_vld_o, 1'b1);
    chk("E_rd5_state", ctx_state_o, 7'h01);
    ctx_rd_i = 1'b0; ctx_wr_i = 1'b1; ctx_wr_idx_i = 7'd5; ctx_wr_state_i = 7'h29;
    tick();
    ctx_wr_i = 1'b0;
    chk("E_vld_idle", ctx_vld_o, 1'b0);
    ctx_rd_i = 1'b1; ctx_idx_i = 7'd5;
    #1;
    chk("E_rdy_buf", ctx_rdy_o, 1'b1);
    tick();
    chk("E_byp5_state", ctx_state_o, 7'h29);
    ctx_idx_i = 7'd4;
    tick();
    chk("E_byp4_state", ctx_state_o, 7'h00);
    ctx_rd_i = 1'b0;
    #1;
    chk("E_commit_bus", {ram_cen_o, ram_wen_o, ram_addr_o, ram_data_o}, {2'b00, 6'd2, 16'h2900});
    tick();
    chk("E_mem2", mem[2], 16'h2900);
    chk("E_buf_empty", ram_cen_o, 1'b1);

    // F: write idx 10 fills the buffer, then read+write idx 40 stalls while word 5 commits
    ctx_rd_i = 1'b1; ctx_idx_i = 7'd10;
    tick();
    chk("F_rd10_state", ctx_state_o, 7'h00);
    ctx_rd_i = 1'b0; ctx_wr_i = 1'b1; ctx_wr_idx_i = 7'd10; ctx_wr_state_i = 7'h33;
    tick();
    ctx_rd_i = 1'b1; ctx_idx_i = 7'd40; ctx_wr_i = 1'b1; ctx_wr_idx_i = 7'd40; ctx_wr_state_i = 7'h15;
    #1;
    chk("F_rdy_stall", ctx_rdy_o, 1'b0);
    chk("F_commit_bus", {ram_cen_o, ram_wen_o, ram_addr_o, ram_data_o}, {2'b00, 6'd5, 16'h0133});
    tick();
    ctx_wr_i = 1'b0;
    chk("F_vld_stalled", ctx_vld_o, 1'b0);
    #1;
    chk("F_rdy_retry", ctx_rdy_o, 1'b1);
    tick();
    chk("F_rd40_vld", ctx_vld_o, 1'b1);
    chk("F_rd40_state", ctx_state_o, 7'h15);
    chk("F_mem5", mem[5], 16'h0133);

    // G: async reset while a read is in flight and word 20 is still buffered
    ctx_idx_i = 7'd41;
    tick();
    ctx_rd_i = 1'b0;
    w0 = wr_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("G_vld_rst", ctx_vld_o, 1'b0);
    chk("G_ram_idle", {ram_cen_o, ram_wen_o}, 2'b11);
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("G_no_write", wr_cnt - w0, 0);
    chk("G_mem20", mem[20], 16'h0100);
    chk("G_idle", {init_busy_o, ctx_vld_o}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
